// File: rtl/inverse_ctrl.sv
// inverse_ctrl: loads an NxN matrix, sequences an external inverse engine and buffers its result for readback
module inverse_ctrl #(
  parameter int N = 6,
  parameter int W = 36,
  parameter int LAST_COUNT = 227,
  parameter int CW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [W-1:0]     load_data,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic             ack,
  output logic             eng_en,
  output logic             eng_rst,
  output logic [CW-1:0]    eng_count,
  output logic [N*N*W-1:0] eng_matrix,
  input  logic [N*N*W-1:0] eng_inverse,
  input  logic [5:0]       rd_addr,
  output logic [W-1:0]     rd_data
);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  typedef enum logic [2:0] {IDLE, LOAD, READY, CLEAR, RUN, CAPTURE, DONE} state_t;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [W-1:0] mat [NN];
  logic [W-1:0] res [NN];
  logic hs, ab, last;
  assign ab = abort && state != IDLE;
  assign hs = load_valid && load_ready && !abort;
  assign last = idx == IW'(NN - 1);
  for (genvar k = 0; k < NN; k++) begin : g_pack
    assign eng_matrix[k*W +: W] = mat[k];
  end
  always_comb begin
    nxt = state;
    if (ab) nxt = IDLE;
    else
      case (state)
        IDLE, LOAD: if (hs) nxt = last ? READY : LOAD;
        READY:      if (start) nxt = CLEAR;
        CLEAR:      nxt = RUN;
        RUN:        if (eng_count == CW'(LAST_COUNT)) nxt = CAPTURE;
        CAPTURE:    nxt = DONE;
        DONE:       if (ack) nxt = IDLE;
        default:    nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      for (int k = 0; k < NN; k++) begin
        mat[k] <= '0;
        res[k] <= '0;
      end
      eng_count <= '0;
      eng_en <= 1'b0;
      eng_rst <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      load_ready <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= nxt;
      busy <= nxt inside {CLEAR, RUN, CAPTURE};
      eng_en <= nxt inside {CLEAR, RUN, CAPTURE};
      eng_rst <= ab || nxt == CLEAR;
      done <= nxt == DONE;
      load_ready <= nxt == IDLE || nxt == LOAD;
      eng_count <= (state == RUN && nxt == RUN) ? eng_count + 1'b1 :
                   (nxt == CAPTURE) ? CW'(LAST_COUNT + 1) : '0;
      if (nxt == IDLE && state != IDLE) begin
        idx <= '0;
        for (int k = 0; k < NN; k++) mat[k] <= '0;
      end else if (hs) begin
        mat[idx] <= load_data;
        idx <= last ? '0 : idx + 1'b1;
      end
      if (state == CAPTURE && !ab)
        for (int k = 0; k < NN; k++) res[k] <= eng_inverse[k*W +: W];
      rd_data <= (int'(rd_addr) < NN) ? res[rd_addr] : '0;
    end
  end
endmodule

// File: tb/tb_inverse_ctrl.sv
// tb_inverse_ctrl: scoreboard bench for inverse_ctrl load, run, capture, abort and reset behaviour
module tb_inverse_ctrl;
  localparam int N = 6;
  localparam int W = 36;
  localparam int LC = 227;
  localparam int CW = 8;
  localparam int NN = N * N;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_valid = 1'b0;
  logic load_ready;
  logic [W-1:0] load_data = '0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  logic ack = 1'b0;
  logic eng_en, eng_rst;
  logic [CW-1:0] eng_count;
  logic [NN*W-1:0] eng_matrix, eng_inverse;
  logic [5:0] rd_addr = '0;
  logic [W-1:0] rd_data;
  logic [W-1:0] gen = 36'h1;
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  inverse_ctrl #(.N(N), .W(W), .LAST_COUNT(LC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .start(start), .abort(abort), .busy(busy), .done(done),
    .ack(ack), .eng_en(eng_en), .eng_rst(eng_rst), .eng_count(eng_count),
    .eng_matrix(eng_matrix), .eng_inverse(eng_inverse), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  always_comb begin
    eng_inverse = '0;
    for (int k = 0; k < NN; k++)
      eng_inverse[k*W +: W] = (eng_en && eng_count == CW'(LC + 1)) ?
                              ((k % 7 == 0) ? gen : '0) : 36'hBAD00 + W'(k);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [5:0] a, input logic [W-1:0] e);
    rd_addr = a;
    exp_q.push_back(e);
    tick();
    chk("rd_data", rd_data, exp_q.pop_front());
  endtask
  task automatic chk_mat(input string tag, input logic [W-1:0] base, input logic zero);
    for (int k = 0; k < NN; k++)
      chk(tag, eng_matrix[k*W +: W], zero ? '0 : base + W'(k));
  endtask
  task automatic load_all(input logic [W-1:0] base);
    int acc = 0;
    for (int k = 0; k < NN; k++) begin
      load_valid = 1'b1;
      load_data = base + W'(k);
      if (load_ready) acc++;
      tick();
    end
    load_valid = 1'b0;
    chk("load_acc", acc, NN);
    chk("ready_no_load", load_ready, 0);
    chk_mat("matrix", base, 1'b0);
  endtask
  task automatic wait_cnt(input int tgt);
    for (int i = 0; i < 400 && eng_count != CW'(tgt); i++) tick();
    chk("wait_cnt", eng_count, tgt);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_load_ready", load_ready, 0);
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_eng_en", eng_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", eng_count, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();
    chk("rel_load_ready", load_ready, 1);
    chk("rel_eng_rst", eng_rst, 0);
    load_all(36'd1);
    start = 1'b1;
    tick();
    chk("clr_eng_rst", eng_rst, 1);
    chk("clr_eng_en", eng_en, 1);
    chk("clr_count", eng_count, 0);
    chk("clr_busy", busy, 1);
    for (int c = 0; c <= LC; c++) begin
      tick();
      chk("run_count", eng_count, c);
      chk("run_eng_rst", eng_rst, 0);
      chk("run_eng_en", eng_en, 1);
    end
    tick();
    chk("cap_count", eng_count, LC + 1);
    chk("cap_busy", busy, 1);
    chk("cap_done", done, 0);
    tick();
    chk("done_done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_eng_en", eng_en, 0);
    chk("done_count", eng_count, 0);
    rd(6'd0, 36'h1);
    rd(6'd7, 36'h1);
    rd(6'd1, 36'h0);
    rd(6'd40, 36'h0);
    rd(6'd35, 36'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_done", done, 0);
    chk("ack_load_ready", load_ready, 1);
    chk_mat("ack_matrix", '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_start_ignored", busy, 0);
    end
    start = 1'b0;
    begin
      int n = 0;
      for (int cyc = 0; cyc < 200 && n < NN; cyc++) begin
        load_valid = (cyc % 2 == 0);
        load_data = 36'd100 + W'(n);
        start = n >= 10 && n < 20;
        if (load_valid) chk("tog_accept", load_ready, 1);
        tick();
        if (load_valid) n++;
        chk("tog_no_run", busy, 0);
      end
      load_valid = 1'b0;
      start = 1'b0;
      chk("tog_count", n, NN);
    end
    chk("tog_ready", load_ready, 0);
    chk_mat("tog_matrix", 36'd100, 1'b0);
    gen = 36'h5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_cnt(100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_load_ready", load_ready, 1);
    chk("abort_eng_rst", eng_rst, 1);
    chk("abort_busy", busy, 0);
    chk("abort_count", eng_count, 0);
    chk_mat("abort_matrix", '0, 1'b1);
    tick();
    chk("abort_eng_rst_off", eng_rst, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    rd(6'd0, 36'h1);
    rd(6'd21, 36'h1);
    rd(6'd2, 36'h0);
    load_all(36'd200);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_cnt(50);
    rst = 1'b1;
    tick();
    chk("mid_rst_load_ready", load_ready, 0);
    chk("mid_rst_eng_rst", eng_rst, 1);
    chk("mid_rst_eng_en", eng_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", eng_count, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk_mat("mid_rst_matrix", '0, 1'b1);
    rst = 1'b0;
    tick();
    chk("mid_rel_load_ready", load_ready, 1);
    chk("mid_rel_eng_rst", eng_rst, 0);
    chk("mid_rel_done", done, 0);
    rd(6'd0, 36'h0);
    load_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load_data = 36'd1 + W'(k);
      tick();
    end
    load_data = 36'd999;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    load_valid = 1'b0;
    chk("abort_load_ready2", load_ready, 1);
    for (int k = 0; k < 4; k++) chk("abort_no_write", eng_matrix[k*W +: W], 0);
    load_all(36'd300);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && !done; i++) tick();
    chk("done_wait", done, 1);
    rd(6'd0, 36'h5);
    rd(6'd7, 36'h5);
    rd(6'd3, 36'h0);
    rd(6'd63, 36'h0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack2_load_ready", load_ready, 1);
    chk("ack2_done", done, 0);
    chk_mat("ack2_matrix", '0, 1'b1);
    rd(6'd14, 36'h5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inverse_ctrl.md
INVERSE_CTRL -- requirements
Module: inverse_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 6, matrix dimension; W, default 36, element width; LAST_COUNT, default 227, final engine count value; CW, default 8, count width.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 load_valid  in  1  input element offered; load_ready  out  1  element accepted when both high.
REQ-005 load_data  in  W  element, row-major, element k = row k/N, col k%N.
REQ-006 start  in  1  begin inversion; abort  in  1  cancel current operation.
REQ-007 busy  out  1  CLEAR/RUN/CAPTURE active; done  out  1  result held; ack  in  1  result consumed.
REQ-008 eng_en  out  1; eng_rst  out  1; eng_count  out  CW  sequencing of the inverse engine.
REQ-009 eng_matrix  out  N*N*W  element k at bits [k*W +: W]; eng_inverse  in  N*N*W  same packing.
REQ-010 rd_addr  in  6  result element index; rd_data  out  W  registered result element.

Function
REQ-011 States SHALL be IDLE, LOAD, READY, CLEAR, RUN, CAPTURE, DONE.
REQ-012 load_ready SHALL be 1 only in IDLE and LOAD; each handshake writes load_data to element index idx, then idx+1.
REQ-013 IDLE->LOAD on first handshake; LOAD->READY on the handshake with idx = N*N-1; idx then wraps to 0.
REQ-014 start SHALL be ignored in IDLE and LOAD; in READY, start=1 SHALL move to CLEAR next cycle.
REQ-015 CLEAR: 1 cycle, eng_rst=1, eng_en=1, eng_count=0.
REQ-016 RUN: eng_en=1, eng_rst=0, eng_count steps 0,1,...,LAST_COUNT, one per cycle, LAST_COUNT+1 cycles total, then CAPTURE.
REQ-017 CAPTURE: 1 cycle, eng_en=1, eng_count=LAST_COUNT+1; result buffer SHALL register eng_inverse at the end of this cycle; then DONE.
REQ-018 DONE: done=1, busy=0, eng_en=0, eng_count=0; ack=1 -> IDLE; matrix register cleared to 0, idx=0.
REQ-019 busy SHALL be 1 exactly in CLEAR, RUN, CAPTURE; eng_en=0 in IDLE, LOAD, READY, DONE.
REQ-020 eng_matrix SHALL be driven from the matrix register and remain stable from READY through CAPTURE.
REQ-021 rd_data SHALL equal result element rd_addr one cycle after rd_addr is sampled; rd_addr >= N*N returns 0; readable in any state.
REQ-022 Result buffer SHALL retain its value until the next CAPTURE, including across abort and ack.
REQ-023 abort=1 in any state other than IDLE SHALL go to IDLE next cycle with eng_rst=1 for that cycle, idx=0, matrix register cleared; result buffer unchanged.
REQ-024 Priority: rst > abort > ack/start/load handshake; abort with load_valid in same cycle SHALL not write the element.
REQ-025 start held high across states SHALL trigger only one run per READY entry; ack outside DONE SHALL be ignored.

Reset
REQ-026 rst=1 SHALL force IDLE, idx=0, matrix register and result buffer to 0, eng_count=0, eng_en=0, eng_rst=1, busy=0, done=0, load_ready=0, rd_data=0 on the next edge.
REQ-027 rst asserted mid-RUN SHALL terminate the run with no CAPTURE; the first cycle after rst release shows IDLE, load_ready=1, eng_rst=0.

Verification
REQ-028 Load 36 elements 1..36 with load_valid always high -> 36 accepts in 36 cycles, READY, eng_matrix[k*36 +: 36]=k+1.
REQ-029 Start sampled at cycle 0 in READY -> CLEAR cycle 1, eng_count 0..227 over cycles 2..229, CAPTURE cycle 230 (count 228), done=1 from cycle 231.
REQ-030 Engine model returns 36'h1 on diagonal, 0 elsewhere -> rd_addr 0 and 7 give 36'h1, rd_addr 1 gives 0, rd_addr 40 gives 0, each one cycle later.
REQ-031 abort at eng_count=100 -> IDLE next cycle, eng_rst=1 one cycle, done never asserts, previous result still readable.
REQ-032 load_valid toggling 1,0,1 with start during LOAD at idx=10 -> start ignored, accepts only on valid cycles, no run until READY.
REQ-033 rst at eng_count=50 -> all outputs at reset values next cycle; ack after DONE -> IDLE, matrix 0, load_ready=1.
